prog_loader: RTL

Byte-stream program loader that sits directly upstream of the microcontroller's program memory. It receives a framed program image over a valid/ready byte interface, assembles 12-bit instructions, and drives the program memory load port (load enable, load address, load instruction). Once the whole frame has arrived and its checksum matches, it raises `load_done`, which releases the controller from its LOAD state.

---
 rtl/prog_loader.sv | 98 +++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Framed byte-stream loader: COUNT, HI/LO instruction pairs and a CHK byte
// are assembled into 12-bit words and written into program memory.
module prog_loader #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          LE,
    output logic [AW-1:0] LA,
    output logic [11:0]   LI,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   word_count
);

    typedef enum logic [2:0] {
        S_COUNT,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t     state;
    logic [7:0] n_words;
    logic [7:0] hi_byte;
    logic [7:0] acc;
    logic       take;
    logic       last_word;

    assign in_ready  = (state != S_DONE) && (state != S_ERR);
    // A byte arriving together with start belongs to the aborted frame.
    assign take      = in_valid && in_ready && !start;
    assign last_word = ((word_count + 1'b1) == (AW+1)'(n_words));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_COUNT;
            n_words    <= '0;
            hi_byte    <= '0;
            acc        <= '0;
            LE         <= 1'b0;
            LA         <= '0;
            LI         <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
        end else begin
            LE <= 1'b0;
            if (start) begin
                state      <= S_COUNT;
                acc        <= '0;
                LA         <= '0;
                LI         <= '0;
                load_done  <= 1'b0;
                load_err   <= 1'b0;
                word_count <= '0;
            end else if (take) begin
                case (state)
                    S_COUNT: begin
                        n_words <= in_data;
                        acc     <= in_data;
                        state   <= (in_data == 8'd0) ? S_CHK : S_HI;
                    end
                    S_HI: begin
                        hi_byte <= in_data;
                        acc     <= acc ^ in_data;
                        state   <= S_LO;
                    end
                    S_LO: begin
                        acc        <= acc ^ in_data;
                        LE         <= 1'b1;
                        LA         <= word_count[AW-1:0];
                        LI         <= {hi_byte[3:0], in_data};
                        word_count <= word_count + 1'b1;
                        state      <= last_word ? S_CHK : S_HI;
                    end
                    S_CHK: begin
                        if (in_data == acc) begin
                            load_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            load_err <= 1'b1;
                            state    <= S_ERR;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule
